// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch sequencer for the pipelined MIPS core.
// Waits for branch source operands (stalling ID), evaluates the condition from
// the external comparator flags, and emits a registered one-cycle redirect /
// resolve pulse. Keeps saturating resolved/taken/stall statistics.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_pc,
    input  logic [15:0]      br_imm,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_equal,
    input  logic             cmp_ltz,
    input  logic             cmp_eqz,
    output logic             stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             resolved,
    output logic             resolved_taken,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Operands needed by each op: two-register compares need rs and rt,
    // compare-with-zero ops need rs only, reserved ops need nothing.
    function automatic logic ops_ready(input logic [2:0] op, input logic rs_rdy,
                                       input logic rt_rdy);
        logic rdy;
        case (op)
            OP_BEQ, OP_BNE:                     rdy = rs_rdy & rt_rdy;
            OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: rdy = rs_rdy;
            default:                            rdy = 1'b1;
        endcase
        return rdy;
    endfunction

    // Branch condition from the comparator flags; reserved ops never take.
    function automatic logic branch_taken(input logic [2:0] op, input logic eq,
                                          input logic ltz, input logic eqz);
        logic tk;
        case (op)
            OP_BEQ:  tk = eq;
            OP_BNE:  tk = ~eq;
            OP_BLEZ: tk = ltz | eqz;
            OP_BGTZ: tk = ~ltz & ~eqz;
            OP_BLTZ: tk = ltz;
            OP_BGEZ: tk = ~ltz;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    // Target = pc + 4 + sext(imm) * 4, wrapping modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (&c) begin
            r = c;
        end else begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [31:0]        pc_q;
    logic [15:0]        imm_q;

    logic [2:0]         op_s;
    logic [31:0]        pc_s;
    logic [15:0]        imm_s;
    logic               active_s;
    logic               ready_s;
    logic               stall_s;
    logic               decide_s;
    logic               taken_s;

    logic               resolved_q;
    logic               resolved_taken_q;
    logic               redirect_valid_q;
    logic [31:0]        redirect_pc_q;
    logic [CNT_W-1:0]   cnt_resolved_q;
    logic [CNT_W-1:0]   cnt_taken_q;
    logic [CNT_W-1:0]   cnt_stall_q;

    // The comparator always sees the live forwarded operands.
    assign cmp_a = rs_val;
    assign cmp_b = rt_val;

    // Select the branch being worked on: the latched one while waiting, else live ID.
    always_comb begin
        op_s     = br_op;
        pc_s     = br_pc;
        imm_s    = br_imm;
        active_s = br_valid;
        if (state_q == ST_WAIT) begin
            op_s     = op_q;
            pc_s     = pc_q;
            imm_s    = imm_q;
            active_s = 1'b1;
        end else begin
            op_s     = br_op;
            pc_s     = br_pc;
            imm_s    = br_imm;
            active_s = br_valid;
        end
    end

    assign ready_s = ops_ready(op_s, rs_ready, rt_ready);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (br_valid && !ready_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ready_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: stall while operands are missing (forced low in reset and on flush).
    always_comb begin
        stall_s  = 1'b0;
        decide_s = 1'b0;
        taken_s  = 1'b0;
        if (reset && !flush && active_s) begin
            stall_s  = ~ready_s;
            decide_s = ready_s;
            taken_s  = ready_s & branch_taken(op_s, cmp_equal, cmp_ltz, cmp_eqz);
        end else begin
            stall_s  = 1'b0;
            decide_s = 1'b0;
            taken_s  = 1'b0;
        end
    end

    assign stall = stall_s;

    // Capture the branch fields when ID has to wait for operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= 3'd0;
            pc_q  <= 32'd0;
            imm_q <= 16'd0;
        end else if (state_q == ST_IDLE && br_valid && !ready_s && !flush) begin
            op_q  <= br_op;
            pc_q  <= br_pc;
            imm_q <= br_imm;
        end else begin
            op_q  <= op_q;
            pc_q  <= pc_q;
            imm_q <= imm_q;
        end
    end

    // Register the decision: one-cycle resolve/redirect pulses, sticky target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resolved_q       <= 1'b0;
            resolved_taken_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            resolved_q       <= decide_s;
            resolved_taken_q <= taken_s;
            redirect_valid_q <= taken_s;
            if (taken_s) begin
                redirect_pc_q <= branch_target(pc_s, imm_s);
            end else begin
                redirect_pc_q <= redirect_pc_q;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_resolved_q <= {CNT_W{1'b0}};
            cnt_taken_q    <= {CNT_W{1'b0}};
            cnt_stall_q    <= {CNT_W{1'b0}};
        end else begin
            cnt_resolved_q <= decide_s ? sat_inc(cnt_resolved_q) : cnt_resolved_q;
            cnt_taken_q    <= taken_s  ? sat_inc(cnt_taken_q)    : cnt_taken_q;
            cnt_stall_q    <= stall_s  ? sat_inc(cnt_stall_q)    : cnt_stall_q;
        end
    end

    assign resolved       = resolved_q;
    assign resolved_taken = resolved_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign cnt_resolved   = cnt_resolved_q;
    assign cnt_taken      = cnt_taken_q;
    assign cnt_stall      = cnt_stall_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios then randomized traffic, checked
// against a behavioural model (signed arithmetic, pending-branch record).
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_branch_ctrl;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] br_pc;
    logic [15:0] br_imm;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cmp_equal, cmp_ltz, cmp_eqz;

    logic [31:0] cmp_a, cmp_b;
    logic        stall, redirect_valid, resolved, resolved_taken;
    logic [31:0] redirect_pc;
    logic [15:0] cnt_resolved, cnt_taken, cnt_stall;

    logic [31:0] cmp_a2, cmp_b2;
    logic        stall2, redirect_valid2, resolved2, resolved_taken2;
    logic [31:0] redirect_pc2;
    logic [1:0]  cnt_resolved2, cnt_taken2, cnt_stall2;

    // Comparator of the ID stage, modelled directly from the operand values.
    assign cmp_equal = (rs_val == rt_val);
    assign cmp_ltz   = ($signed(rs_val) < 0);
    assign cmp_eqz   = (rs_val == 32'd0);

    branch_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid),
        .br_op(br_op), .br_pc(br_pc), .br_imm(br_imm),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .rs_val(rs_val), .rt_val(rt_val),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_equal(cmp_equal), .cmp_ltz(cmp_ltz), .cmp_eqz(cmp_eqz),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resolved(resolved), .resolved_taken(resolved_taken),
        .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
    );

    branch_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid),
        .br_op(br_op), .br_pc(br_pc), .br_imm(br_imm),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .rs_val(rs_val), .rt_val(rt_val),
        .cmp_a(cmp_a2), .cmp_b(cmp_b2),
        .cmp_equal(cmp_equal), .cmp_ltz(cmp_ltz), .cmp_eqz(cmp_eqz),
        .stall(stall2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .resolved(resolved2), .resolved_taken(resolved_taken2),
        .cnt_resolved(cnt_resolved2), .cnt_taken(cnt_taken2), .cnt_stall(cnt_stall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_pend;
    logic [2:0]  m_op;
    logic [31:0] m_pc;
    logic [15:0] m_imm;
    int unsigned m_res, m_tk, m_st;
    logic        e_res, e_tk, e_rv;
    logic [31:0] e_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_taken(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int unsigned sat(input int unsigned c, input int unsigned mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_op = 3'd0; m_pc = 32'd0; m_imm = 16'd0;
        m_res = 0; m_tk = 0; m_st = 0;
        e_res = 1'b0; e_tk = 1'b0; e_rv = 1'b0; e_pc = 32'd0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".resolved"},  32'(resolved),       32'(e_res));
        chk({tag, ".taken"},     32'(resolved_taken), 32'(e_tk));
        chk({tag, ".rv"},        32'(redirect_valid), 32'(e_rv));
        chk({tag, ".rpc"},       redirect_pc,         e_pc);
        chk({tag, ".cnt_res"},   32'(cnt_resolved),   sat(m_res, 65535));
        chk({tag, ".cnt_tk"},    32'(cnt_taken),      sat(m_tk, 65535));
        chk({tag, ".cnt_st"},    32'(cnt_stall),      sat(m_st, 65535));
        chk({tag, ".rv2"},       32'(redirect_valid2), 32'(e_rv));
        chk({tag, ".rpc2"},      redirect_pc2,        e_pc);
        chk({tag, ".cnt_res2"},  32'(cnt_resolved2),  sat(m_res, 3));
        chk({tag, ".cnt_tk2"},   32'(cnt_taken2),     sat(m_tk, 3));
        chk({tag, ".cnt_st2"},   32'(cnt_stall2),     sat(m_st, 3));
    endtask

    // One clock cycle: inputs are already driven (just after an edge).
    task automatic cycle(input string tag);
        logic [2:0]  op;
        logic [31:0] pc;
        logic [15:0] imm;
        bit act, rdy, stl, dec, tk;
        #3;
        op  = m_pend ? m_op  : br_op;
        pc  = m_pend ? m_pc  : br_pc;
        imm = m_pend ? m_imm : br_imm;
        act = m_pend || br_valid;
        rdy = (op >= 3'd6) || (rs_ready && (op >= 3'd2 || rt_ready));
        stl = act && !rdy && !flush;
        dec = act && rdy && !flush;
        tk  = dec && cond_taken(op, rs_val, rt_val);
        chk({tag, ".stall"},  32'(stall),  32'(stl));
        chk({tag, ".stall2"}, 32'(stall2), 32'(stl));
        chk({tag, ".cmp_a"},  cmp_a, rs_val);
        chk({tag, ".cmp_b"},  cmp_b, rt_val);
        @(posedge clk);
        #1;
        if (flush || dec) begin
            m_pend = 1'b0;
        end else if (stl && !m_pend) begin
            m_pend = 1'b1; m_op = br_op; m_pc = br_pc; m_imm = br_imm;
        end
        e_res = dec; e_tk = tk; e_rv = tk;
        if (tk) e_pc = pc + 32'd4 + 32'(int'($signed(imm)) * 4);
        if (dec) m_res++;
        if (tk)  m_tk++;
        if (stl) m_st++;
        check_regs(tag);
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        rs_val = a;
        rt_val = b;
    endtask

    int unsigned saved_res;

    initial begin
        // Reset with a not-ready branch presented: stall must stay low.
        reset = 1'b0; flush = 1'b0; br_valid = 1'b1; br_op = 3'd1;
        br_pc = 32'h0; br_imm = 16'h0; rs_ready = 1'b0; rt_ready = 1'b0;
        set_ops(32'd0, 32'd0);
        model_reset();
        #2;
        chk("rst.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_regs("rst");
        br_valid = 1'b0;
        reset = 1'b1;

        // beq taken, operands ready: no stall, redirect next cycle.
        br_valid = 1'b1; br_op = 3'd0; br_pc = 32'h3000; br_imm = 16'h0003;
        rs_ready = 1'b1; rt_ready = 1'b1; set_ops(32'h5, 32'h5);
        cycle("beq");
        chk("beq.pc_lit", redirect_pc, 32'h0000_3010);
        chk("beq.tk_lit", 32'(cnt_taken), 32'd1);
        br_valid = 1'b0;
        cycle("beq.after");

        // bne with rs missing for three cycles; live br_* changes are ignored in WAIT.
        br_valid = 1'b1; br_op = 3'd1; br_pc = 32'h4000; br_imm = 16'h0010;
        rs_ready = 1'b0; rt_ready = 1'b1; set_ops(32'd1, 32'd2);
        cycle("bne.w0");
        br_valid = 1'b0; br_op = 3'd0; br_pc = 32'h9999_0000;
        cycle("bne.w1");
        cycle("bne.w2");
        rs_ready = 1'b1;
        cycle("bne.go");
        chk("bne.st_lit", 32'(cnt_stall), 32'd3);
        chk("bne.pc_lit", redirect_pc, 32'h0000_4044);

        // bltz on a negative operand with a negative offset, then bgez not taken.
        br_valid = 1'b1; br_op = 3'd4; br_pc = 32'h3004; br_imm = 16'hFFFF;
        rs_ready = 1'b1; rt_ready = 1'b0; set_ops(32'h8000_0000, 32'd7);
        cycle("bltz");
        chk("bltz.pc_lit", redirect_pc, 32'h0000_3004);
        br_op = 3'd5; br_pc = 32'h5000;
        cycle("bgez");
        chk("bgez.res_lit", 32'(resolved), 32'd1);
        chk("bgez.tk_lit", 32'(resolved_taken), 32'd0);

        // Flush arriving together with operand readiness in WAIT.
        br_op = 3'd1; br_pc = 32'h6000; br_imm = 16'h0001;
        rs_ready = 1'b0; rt_ready = 1'b1; set_ops(32'd3, 32'd4);
        cycle("fl.w");
        saved_res = 32'(cnt_resolved);
        br_valid = 1'b0; rs_ready = 1'b1; flush = 1'b1;
        cycle("fl.hit");
        chk("fl.res_lit", 32'(resolved), 32'd0);
        chk("fl.cnt_lit", 32'(cnt_resolved), saved_res);
        flush = 1'b0; rs_ready = 1'b0;
        cycle("fl.idle");

        // Asynchronous reset while stalled in WAIT.
        br_valid = 1'b1; br_op = 3'd1; rs_ready = 1'b0;
        cycle("ar.w");
        #2;
        chk("ar.pre_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("ar.stall", 32'(stall), 32'd0);
        chk("ar.stall2", 32'(stall2), 32'd0);
        check_regs("ar");
        @(posedge clk); #1;
        check_regs("ar.hold");
        reset = 1'b1;

        // Five taken branches: the 2-bit instance saturates at 3.
        br_valid = 1'b1; br_op = 3'd0; rs_ready = 1'b1; rt_ready = 1'b1;
        set_ops(32'h11, 32'h11);
        for (int i = 0; i < 5; i++) begin
            br_pc = 32'h7000 + 32'(i * 4);
            cycle("sat");
        end
        chk("sat.tk2_lit", 32'(cnt_taken2), 32'd3);
        chk("sat.tk_lit",  32'(cnt_taken),  32'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            br_valid = ($urandom_range(0, 3) != 0);
            br_op    = 3'($urandom_range(0, 7));
            br_pc    = $urandom;
            br_imm   = 16'($urandom);
            rs_ready = ($urandom_range(0, 2) != 0);
            rt_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       rs_val = 32'd0;
                1:       rs_val = 32'h8000_0000 | $urandom;
                2:       rs_val = 32'($urandom_range(1, 100));
                default: rs_val = $urandom;
            endcase
            rt_val = ($urandom_range(0, 1) == 0) ? rs_val : $urandom;
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
